// File: rtl/data_arith_extend_sched_pkg.sv
// Shared types for the extend scheduler: control bundle, signedness select, index sizing.
package data_arith_extend_sched_pkg;

  typedef struct packed {
    logic clk;
    logic rst;
  } data_control_t;

  typedef enum logic {
    EXT_UNSIGNED = 1'b0,
    EXT_SIGNED   = 1'b1
  } data_sign_e;

  // Requester index width; a single requester still needs a 1-bit id.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_arith_extend_sched_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module data_arith_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      k = (32'(ptr) + off) % N;
      if (!any && elig[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/data_arith_extend_sched.sv
// Round-robin scheduler sharing one sign/zero-extend pipeline among N_REQ requesters.
module data_arith_extend_sched
  import data_arith_extend_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned IN_W    = 4,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  data_control_t                  ctrl,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][IN_W-1:0]     req_data,
  input  logic [N_REQ-1:0]               req_sign,
  output logic [N_REQ-1:0]               rsp_valid,
  input  logic [N_REQ-1:0]               rsp_ready,
  output logic [N_REQ-1:0][OUT_W-1:0]    rsp_data,
  output logic                           busy
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] id;
    logic [OUT_W-1:0] data;
  } stage_t;

  logic clk;
  logic rst;
  assign clk = ctrl.clk;
  assign rst = ctrl.rst;

  logic [N_REQ-1:0] inflight;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] retire_oh;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic             gany;
  logic [IN_W-1:0]  gdata;
  logic [OUT_W-1:0] ext;
  stage_t           issue_s;
  stage_t           retire_s;

  // A held result blocks its owner unless it is being consumed this cycle.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      elig[i] = !rst && req_valid[i] && !inflight[i] && (!rsp_valid[i] || rsp_ready[i]);
  end

  data_arith_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign req_ready = grant;

  always_comb begin
    gdata = req_data[gidx];
    ext   = {{(OUT_W-IN_W){1'b0}}, gdata};
    if (data_sign_e'(req_sign[gidx]) == EXT_SIGNED)
      ext = {{(OUT_W-IN_W){gdata[IN_W-1]}}, gdata};
    issue_s = '{valid: gany, id: gidx, data: ext};
  end

  // The result register is the last extend stage, so only LATENCY-1 stages sit in between.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign retire_s = issue_s;
    end else begin : g_pipe
      stage_t sh [LATENCY-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < LATENCY-1; i++) sh[i] <= '0;
        end else begin
          sh[0] <= issue_s;
          for (int unsigned i = 1; i < LATENCY-1; i++) sh[i] <= sh[i-1];
        end
      end
      assign retire_s = sh[LATENCY-2];
    end
  endgenerate

  always_comb begin
    retire_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      retire_oh[i] = retire_s.valid && (retire_s.id == IDX_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      inflight  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (gany)
        ptr <= (gidx == IDX_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
      inflight <= (inflight | grant) & ~retire_oh;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (retire_oh[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_data[i]  <= retire_s.data;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = (|inflight) || (|rsp_valid);

endmodule

// File: tb/tb_data_arith_extend_sched.sv
// Directed bench for the extend scheduler: LATENCY=1 instance plus a LATENCY=3 instance.
module tb_data_arith_extend_sched;
  import data_arith_extend_sched_pkg::*;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst1 = 1'b1;
  data_control_t    ctrl1;
  logic [1:0]       v1 = 2'b11, rdy1, s1 = 2'b00, rv1, rr1 = 2'b11;
  logic [1:0][3:0]  d1 = '0;
  logic [1:0][7:0]  rd1;
  logic             busy1;

  logic             rst3 = 1'b1;
  data_control_t    ctrl3;
  logic [1:0]       v3 = 2'b00, rdy3, s3 = 2'b00, rv3, rr3 = 2'b11;
  logic [1:0][3:0]  d3 = '0;
  logic [1:0][7:0]  rd3;
  logic             busy3;

  assign ctrl1 = '{clk: clk, rst: rst1};
  assign ctrl3 = '{clk: clk, rst: rst3};

  data_arith_extend_sched #(.N_REQ(2), .IN_W(4), .OUT_W(8), .LATENCY(1)) dut (
    .ctrl(ctrl1), .req_valid(v1), .req_ready(rdy1), .req_data(d1), .req_sign(s1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_data(rd1), .busy(busy1)
  );

  data_arith_extend_sched #(.N_REQ(2), .IN_W(4), .OUT_W(8), .LATENCY(3)) dut3 (
    .ctrl(ctrl3), .req_valid(v3), .req_ready(rdy3), .req_data(d3), .req_sign(s3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_data(rd3), .busy(busy3)
  );

  task automatic test_reset();
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (rdy1 !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", rdy1); end
      checks++; if (rv1 !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rv1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
    end
    @(negedge clk);
    rst1 = 1'b0; v1 = 2'b00;
  endtask

  task automatic pulse_reset1();
    @(negedge clk); rst1 = 1'b1; v1 = 2'b00;
    @(negedge clk); rst1 = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    v1 = 2'b01; d1[0] = 4'ha; s1[0] = 1'b1; rr1 = 2'b11; #1;
    checks++; if (rdy1 !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", rdy1); end
    @(negedge clk); v1 = 2'b00; #1;
    checks++; if (rv1 !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", rv1); end
    checks++; if (rd1[0] !== 8'hfa) begin errors++; $display("FAIL single_rsp_data got %h exp fa", rd1[0]); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy1); end
    checks++; if (rdy1 !== 2'b00) begin errors++; $display("FAIL single_ready_drop got %b exp 00", rdy1); end
    @(negedge clk); #1;
    checks++; if (rv1 !== 2'b00) begin errors++; $display("FAIL single_consumed got %b exp 00", rv1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy1); end
  endtask

  task automatic test_pair();
    @(negedge clk);
    v1 = 2'b11; d1[0] = 4'ha; s1[0] = 1'b0; d1[1] = 4'h5; s1[1] = 1'b1; #1;
    checks++; if (rdy1 !== 2'b01) begin errors++; $display("FAIL pair_first got %b exp 01", rdy1); end
    @(negedge clk); v1 = 2'b10; #1;
    checks++; if (rdy1 !== 2'b10) begin errors++; $display("FAIL pair_second got %b exp 10", rdy1); end
    checks++; if (rv1 !== 2'b01) begin errors++; $display("FAIL pair_rsp0_valid got %b exp 01", rv1); end
    checks++; if (rd1[0] !== 8'h0a) begin errors++; $display("FAIL pair_rsp0_data got %h exp 0a", rd1[0]); end
    @(negedge clk); v1 = 2'b00; #1;
    checks++; if (rv1 !== 2'b10) begin errors++; $display("FAIL pair_rsp1_valid got %b exp 10", rv1); end
    checks++; if (rd1[1] !== 8'h05) begin errors++; $display("FAIL pair_rsp1_data got %h exp 05", rd1[1]); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    @(negedge clk);
    v1 = 2'b11; d1[0] = 4'h7; s1[0] = 1'b1; d1[1] = 4'h9; s1[1] = 1'b0; rr1 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (rdy1 !== exp_g) begin errors++; $display("FAIL alt_grant%0d got %b exp %b", k, rdy1, exp_g); end
      if (k > 0) begin
        checks++; if (rv1 !== ~exp_g) begin errors++; $display("FAIL alt_rsp%0d got %b exp %b", k, rv1, ~exp_g); end
      end
      @(negedge clk);
    end
    v1 = 2'b00; #1;
    checks++; if (rv1 !== 2'b10) begin errors++; $display("FAIL alt_last_valid got %b exp 10", rv1); end
    checks++; if (rd1[1] !== 8'h09) begin errors++; $display("FAIL alt_data1 got %h exp 09", rd1[1]); end
    checks++; if (rd1[0] !== 8'h07) begin errors++; $display("FAIL alt_data0 got %h exp 07", rd1[0]); end
    @(negedge clk); #1;
    checks++; if (rv1 !== 2'b00) begin errors++; $display("FAIL alt_drain got %b exp 00", rv1); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    rr1 = 2'b10; v1 = 2'b01; d1[0] = 4'h3; s1[0] = 1'b1; #1;
    checks++; if (rdy1 !== 2'b01) begin errors++; $display("FAIL hold_grant0 got %b exp 01", rdy1); end
    @(negedge clk);
    v1 = 2'b11; d1[0] = 4'hf; s1[0] = 1'b1; d1[1] = 4'hc; s1[1] = 1'b0; #1;
    checks++; if (rdy1 !== 2'b10) begin errors++; $display("FAIL hold_block0 got %b exp 10", rdy1); end
    checks++; if (rv1 !== 2'b01) begin errors++; $display("FAIL hold_valid0 got %b exp 01", rv1); end
    checks++; if (rd1[0] !== 8'h03) begin errors++; $display("FAIL hold_data0 got %h exp 03", rd1[0]); end
    @(negedge clk); v1 = 2'b01; #1;
    checks++; if (rdy1 !== 2'b00) begin errors++; $display("FAIL hold_none got %b exp 00", rdy1); end
    checks++; if (rv1 !== 2'b11) begin errors++; $display("FAIL hold_valid_both got %b exp 11", rv1); end
    checks++; if (rd1[0] !== 8'h03) begin errors++; $display("FAIL hold_stable0 got %h exp 03", rd1[0]); end
    checks++; if (rd1[1] !== 8'h0c) begin errors++; $display("FAIL hold_data1 got %h exp 0c", rd1[1]); end
    @(negedge clk); #1;
    checks++; if (rdy1 !== 2'b00) begin errors++; $display("FAIL hold_still_blocked got %b exp 00", rdy1); end
    checks++; if (rv1 !== 2'b01) begin errors++; $display("FAIL hold_only0 got %b exp 01", rv1); end
    checks++; if (rd1[0] !== 8'h03) begin errors++; $display("FAIL hold_stable0b got %h exp 03", rd1[0]); end
    @(negedge clk); rr1 = 2'b11; #1;
    checks++; if (rdy1 !== 2'b01) begin errors++; $display("FAIL hold_regrant got %b exp 01", rdy1); end
    @(negedge clk); v1 = 2'b00; #1;
    checks++; if (rv1 !== 2'b01) begin errors++; $display("FAIL hold_new_valid got %b exp 01", rv1); end
    checks++; if (rd1[0] !== 8'hff) begin errors++; $display("FAIL hold_new_data got %h exp ff", rd1[0]); end
    @(negedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL hold_idle got %b exp 0", busy1); end
  endtask

  task automatic test_lat3_reset();
    @(negedge clk); rst3 = 1'b0;
    @(negedge clk);
    v3 = 2'b11; d3[0] = 4'h1; s3[0] = 1'b0; d3[1] = 4'h2; s3[1] = 1'b0; #1;
    checks++; if (rdy3 !== 2'b01) begin errors++; $display("FAIL lat3_grant0 got %b exp 01", rdy3); end
    @(negedge clk); #1;
    checks++; if (rdy3 !== 2'b10) begin errors++; $display("FAIL lat3_grant1 got %b exp 10", rdy3); end
    @(negedge clk); v3 = 2'b00; rst3 = 1'b1; #1;
    checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL lat3_inflight_busy got %b exp 1", busy3); end
    checks++; if (rv3 !== 2'b00) begin errors++; $display("FAIL lat3_early_rsp got %b exp 00", rv3); end
    @(negedge clk); rst3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (rv3 !== 2'b00) begin errors++; $display("FAIL lat3_dropped%0d got %b exp 00", c, rv3); end
      checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat3_busy%0d got %b exp 0", c, busy3); end
      @(negedge clk);
    end
    v3 = 2'b01; d3[0] = 4'h8; s3[0] = 1'b1; #1;
    checks++; if (rdy3 !== 2'b01) begin errors++; $display("FAIL lat3_fresh_grant got %b exp 01", rdy3); end
    @(negedge clk); v3 = 2'b00; #1;
    checks++; if (rv3 !== 2'b00) begin errors++; $display("FAIL lat3_wait1 got %b exp 00", rv3); end
    checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL lat3_busy_fresh got %b exp 1", busy3); end
    @(negedge clk); #1;
    checks++; if (rv3 !== 2'b00) begin errors++; $display("FAIL lat3_wait2 got %b exp 00", rv3); end
    @(negedge clk); #1;
    checks++; if (rv3 !== 2'b01) begin errors++; $display("FAIL lat3_rsp_valid got %b exp 01", rv3); end
    checks++; if (rd3[0] !== 8'hf8) begin errors++; $display("FAIL lat3_rsp_data got %h exp f8", rd3[0]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    pulse_reset1();
    test_pair();
    test_alternate();
    test_hold();
    test_lat3_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
